// File: rtl/simple_mem_responder.sv
// Memory end of the 256-bit simple line interface: one read or write in flight,
// fixed latency, one-cycle resp pulse, plus sticky initiator protocol checks.
module simple_mem_responder #(
  parameter int LINES   = 16,
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic             read,
  input  logic             write,
  input  logic [255:0]     wdata,
  output logic [255:0]     rdata,
  output logic             resp,
  output logic             error,
  output logic [2:0]       err_flags,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int IDX_W = $clog2(LINES);
  // BUSY lasts LATENCY-1 cycles, so the counter only needs to hold LATENCY-2.
  localparam int BC_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [BC_W-1:0] BC_LOAD = BC_W'((LATENCY > 2) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [BC_W-1:0]   busy_cnt;

  logic              cap_write;
  logic [31:0]       cap_addr;
  logic [255:0]      cap_wdata;

  logic [255:0]      mem [LINES];

  logic              req_one;
  logic              req_both;
  logic              accept;
  logic              commit;
  logic              commit_write;
  logic [IDX_W-1:0]  commit_idx;
  logic [255:0]      commit_wdata;
  logic              hold_violation;

  assign req_one  = read ^ write;
  assign req_both = read & write;
  assign accept   = (state == IDLE) && req_one;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on paths that do not assign state_next explicitly.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (busy_cnt == '0) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    resp = (state == RESP);
  end

  assign error = |err_flags;

  // ---------------------------------------------------------------------------
  // Request capture and latency counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      busy_cnt  <= '0;
    end else begin
      if (accept) begin
        cap_write <= write;
        cap_addr  <= addr;
        cap_wdata <= wdata;
        busy_cnt  <= BC_LOAD;
      end else if ((state == BUSY) && (busy_cnt != '0)) begin
        busy_cnt <= busy_cnt - BC_W'(1);
      end
    end
  end

  // The commit edge is the one entering RESP. With LATENCY=1 that is also the
  // capture edge, so the live bus values stand in for the captured ones.
  assign commit       = (state_next == RESP) && (state != RESP);
  assign commit_write = (state == IDLE) ? write : cap_write;
  assign commit_idx   = (state == IDLE) ? addr[5 +: IDX_W] : cap_addr[5 +: IDX_W];
  assign commit_wdata = (state == IDLE) ? wdata : cap_wdata;

  // ---------------------------------------------------------------------------
  // Line array and read data
  // ---------------------------------------------------------------------------
  // NOTE: the array is built from resettable flops rather than a RAM macro
  // because every line must read back as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LINES; i++) begin
        mem[i] <= '0;
      end
    end else if (commit && commit_write) begin
      mem[commit_idx] <= commit_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (commit && !commit_write) begin
      rdata <= mem[commit_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating transaction counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (commit) begin
      if (commit_write) begin
        if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
      end else begin
        if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  // While BUSY the initiator must hold command, address and (for writes) data.
  assign hold_violation = (state == BUSY) &&
                          ((read  != !cap_write) ||
                           (write != cap_write)  ||
                           (addr  != cap_addr)   ||
                           (cap_write && (wdata != cap_wdata)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_flags <= '0;
    end else begin
      if ((state == IDLE) && req_both) err_flags[0] <= 1'b1;
      if (hold_violation)              err_flags[1] <= 1'b1;
      if (accept && (addr[4:0] != 5'd0)) err_flags[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simple_mem_responder.sv
// Randomized self-checking bench for simple_mem_responder against a line-array
// reference model kept in plain arrays and counters.
module tb_simple_mem_responder;

  localparam int LINES   = 16;
  localparam int LATENCY = 4;
  localparam int CNT_W   = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      addr;
  logic             read;
  logic             write;
  logic [255:0]     wdata;
  logic [255:0]     rdata;
  logic             resp;
  logic             error;
  logic [2:0]       err_flags;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] model_mem [LINES];
  int           model_rd;
  int           model_wr;
  logic [2:0]   model_err;

  always #5 clk = ~clk;

  simple_mem_responder #(
    .LINES  (LINES),
    .LATENCY(LATENCY),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .read     (read),
    .write    (write),
    .wdata    (wdata),
    .rdata    (rdata),
    .resp     (resp),
    .error    (error),
    .err_flags(err_flags),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32'd32) % LINES);
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) model_mem[i] = '0;
    model_rd  = 0;
    model_wr  = 0;
    model_err = 3'b000;
  endfunction

  // Drive one request and wait for resp; lat is the cycle offset at which resp
  // was seen (-1 if never). Optionally change addr after chg_at edges.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [255:0] wd, input int chg_at,
                         input logic [31:0] chg_addr,
                         output logic [255:0] got, output int lat);
    @(negedge clk);
    read  = rd;
    write = wr;
    addr  = a;
    wdata = wd;
    lat   = -1;
    got   = '0;
    for (int k = 1; k <= LATENCY + 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == chg_at) addr = chg_addr;
      if (resp) begin
        lat = k;
        got = rdata;
        break;
      end
    end
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic test_reset();
    rst   = 1'b0;
    read  = 1'b0;
    write = 1'b0;
    addr  = '0;
    wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp !== 1'b0) begin n_errors++; $display("FAIL reset_resp: got %b want 0", resp); end
    n_checks++;
    if (rdata !== 256'd0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++;
    if (err_flags !== 3'b000 || error !== 1'b0) begin
      n_errors++; $display("FAIL reset_err: got flags=%b error=%b want 000/0", err_flags, error);
    end
    n_checks++;
    if (rd_count !== '0 || wr_count !== '0) begin
      n_errors++; $display("FAIL reset_counts: got rd=%0d wr=%0d want 0/0", rd_count, wr_count);
    end
  endtask

  task automatic test_read_basic();
    logic [255:0] got;
    int lat;
    run_txn(1'b1, 1'b0, 32'h0000_0040, '0, 0, '0, got, lat);
    model_rd++;
    n_checks++;
    if (lat !== LATENCY) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", lat, LATENCY); end
    n_checks++;
    if (got !== model_mem[2]) begin n_errors++; $display("FAIL basic_rdata: got %h want %h", got, model_mem[2]); end
    @(negedge clk);
    n_checks++;
    if (resp !== 1'b0) begin n_errors++; $display("FAIL basic_resp_width: resp still %b after one cycle", resp); end
    n_checks++;
    if (rd_count !== CNT_W'(model_rd) || error !== 1'b0) begin
      n_errors++; $display("FAIL basic_status: got rd=%0d error=%b want %0d/0", rd_count, error, model_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] got;
    logic [255:0] wd;
    int lat;
    int wr0, rd0;
    wd  = {8{32'hDEADBEEF}};
    wr0 = model_wr;
    rd0 = model_rd;
    run_txn(1'b0, 1'b1, 32'h0000_0060, wd, 0, '0, got, lat);
    model_mem[line_of(32'h0000_0060)] = wd;
    model_wr++;
    n_checks++;
    if (lat !== LATENCY) begin n_errors++; $display("FAIL b2b_write_latency: got %0d want %0d", lat, LATENCY); end
    run_txn(1'b1, 1'b0, 32'h0000_0060, '0, 0, '0, got, lat);
    model_rd++;
    n_checks++;
    if (lat !== LATENCY) begin n_errors++; $display("FAIL b2b_read_latency: got %0d want %0d", lat, LATENCY); end
    n_checks++;
    if (got !== wd) begin n_errors++; $display("FAIL b2b_rdata: got %h want %h", got, wd); end
    n_checks++;
    if (wr_count !== CNT_W'(wr0 + 1) || rd_count !== CNT_W'(rd0 + 1)) begin
      n_errors++; $display("FAIL b2b_counts: got wr=%0d rd=%0d want %0d/%0d", wr_count, rd_count, wr0 + 1, rd0 + 1);
    end
  endtask

  task automatic test_alias();
    logic [255:0] got;
    logic [255:0] wd;
    int lat;
    wd = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_0020, wd, 0, '0, got, lat);
    model_mem[line_of(32'h0000_0020)] = wd;
    model_wr++;
    run_txn(1'b1, 1'b0, 32'h0000_0220, '0, 0, '0, got, lat);
    model_rd++;
    n_checks++;
    if (got !== wd) begin n_errors++; $display("FAIL alias_rdata: got %h want %h", got, wd); end
    n_checks++;
    if (error !== 1'b0) begin n_errors++; $display("FAIL alias_error: got %b want 0", error); end
  endtask

  task automatic test_both_high();
    logic [255:0] got;
    int lat;
    int seen;
    seen = 0;
    @(negedge clk);
    read  = 1'b1;
    write = 1'b1;
    addr  = 32'h0000_0060;
    wdata = rand_line();
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) seen++;
    end
    read  = 1'b0;
    write = 1'b0;
    model_err[0] = 1'b1;
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL both_resp: got %0d resp pulses want 0", seen); end
    n_checks++;
    if (err_flags !== model_err || error !== 1'b1) begin
      n_errors++; $display("FAIL both_flags: got %b error=%b want %b/1", err_flags, error, model_err);
    end
    n_checks++;
    if (wr_count !== CNT_W'(model_wr) || rd_count !== CNT_W'(model_rd)) begin
      n_errors++; $display("FAIL both_counts: got wr=%0d rd=%0d want %0d/%0d", wr_count, rd_count, model_wr, model_rd);
    end
    run_txn(1'b1, 1'b0, 32'h0000_0060, '0, 0, '0, got, lat);
    model_rd++;
    n_checks++;
    if (got !== model_mem[3]) begin n_errors++; $display("FAIL both_array: got %h want %h", got, model_mem[3]); end
  endtask

  task automatic test_protocol_flags();
    logic [255:0] got;
    logic [255:0] wd;
    int lat;
    wd = rand_line();
    run_txn(1'b0, 1'b1, 32'h0000_0080, wd, 0, '0, got, lat);
    model_mem[4] = wd;
    model_wr++;
    run_txn(1'b1, 1'b0, 32'h0000_0080, '0, 2, 32'h0000_00A0, got, lat);
    model_rd++;
    model_err[1] = 1'b1;
    n_checks++;
    if (lat !== LATENCY) begin n_errors++; $display("FAIL addrchg_latency: got %0d want %0d", lat, LATENCY); end
    n_checks++;
    if (got !== wd) begin n_errors++; $display("FAIL addrchg_rdata: got %h want %h", got, wd); end
    n_checks++;
    if (err_flags !== model_err) begin n_errors++; $display("FAIL addrchg_flags: got %b want %b", err_flags, model_err); end
    run_txn(1'b1, 1'b0, 32'h0000_0084, '0, 0, '0, got, lat);
    model_rd++;
    model_err[2] = 1'b1;
    n_checks++;
    if (got !== wd) begin n_errors++; $display("FAIL unaligned_rdata: got %h want %h", got, wd); end
    n_checks++;
    if (err_flags !== model_err) begin n_errors++; $display("FAIL unaligned_flags: got %b want %b", err_flags, model_err); end
  endtask

  task automatic test_random();
    logic [255:0] got;
    logic [255:0] wd;
    logic [255:0] exp;
    logic [31:0]  a;
    logic         is_wr;
    int lat;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      is_wr = 1'($urandom_range(0, 1));
      a     = $urandom;
      if ($urandom_range(0, 7) != 0) a[4:0] = 5'd0;
      wd    = rand_line();
      exp   = model_mem[line_of(a)];
      run_txn(!is_wr, is_wr, a, wd, 0, '0, got, lat);
      if (is_wr) begin
        model_mem[line_of(a)] = wd;
        model_wr = (model_wr < CNT_MAX) ? model_wr + 1 : model_wr;
      end else begin
        model_rd = (model_rd < CNT_MAX) ? model_rd + 1 : model_rd;
      end
      if (a[4:0] != 5'd0) model_err[2] = 1'b1;
      n_checks++;
      if (lat !== LATENCY) begin n_errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", n, lat, LATENCY); end
      if (!is_wr) begin
        n_checks++;
        if (got !== exp) begin n_errors++; $display("FAIL rand_rdata[%0d] addr=%h: got %h want %h", n, a, got, exp); end
      end
      n_checks++;
      if (rd_count !== CNT_W'(model_rd) || wr_count !== CNT_W'(model_wr) || err_flags !== model_err) begin
        n_errors++;
        $display("FAIL rand_status[%0d]: got rd=%0d wr=%0d flags=%b want %0d/%0d/%b",
                 n, rd_count, wr_count, err_flags, model_rd, model_wr, model_err);
      end
    end
  endtask

  task automatic test_reset_midbusy();
    logic [255:0] got;
    logic [31:0]  a;
    int lat;
    int seen;
    seen = 0;
    @(negedge clk);
    read = 1'b1;
    addr = 32'h0000_0060;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (resp !== 1'b0 || rdata !== 256'd0 || err_flags !== 3'b000 || error !== 1'b0 ||
        rd_count !== '0 || wr_count !== '0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got resp=%b rdata=%h flags=%b error=%b rd=%0d wr=%0d want all 0",
               resp, rdata, err_flags, error, rd_count, wr_count);
    end
    read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL midreset_resp: got %0d resp pulses want 0", seen); end
    for (int n = 0; n < 4; n++) begin
      a = {$urandom_range(0, 1023), 5'd0};
      run_txn(1'b1, 1'b0, a, '0, 0, '0, got, lat);
      model_rd++;
      n_checks++;
      if (got !== 256'd0 || lat !== LATENCY) begin
        n_errors++; $display("FAIL midreset_read[%0d] addr=%h: got %h lat=%0d want 0 lat=%0d", n, a, got, lat, LATENCY);
      end
    end
    n_checks++;
    if (rd_count !== CNT_W'(model_rd) || wr_count !== '0 || err_flags !== 3'b000) begin
      n_errors++;
      $display("FAIL midreset_status: got rd=%0d wr=%0d flags=%b want %0d/0/000", rd_count, wr_count, err_flags, model_rd);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_alias();
    test_both_high();
    test_protocol_flags();
    test_random();
    test_reset_midbusy();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/simple_mem_responder.md
Name: simple_mem_responder

Overview:
Synthesizable responder for the 256-bit simple memory line interface. It is the memory end of the bus driven by cache or arbiter initiators. It services one line read or line write at a time from a small internal line array, with fixed configurable latency and a one-cycle resp pulse. It also checks initiator protocol compliance and reports violations on a sticky error output, so it doubles as the bench memory and a lightweight monitor.

Parameters:
LINES, 16, number of 256-bit lines in the array (power of 2, >=2)
LATENCY, 4, cycles from request first seen to resp asserted (>=1)
CNT_W, 16, width of the read/write transaction counters

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
addr  input  32  byte address of line; line index = addr[5+$clog2(LINES)-1:5]
read  input  1  line read request, held until resp
write  input  1  line write request, held until resp
wdata  input  256  write line data, held with write until resp
rdata  output  256  read line data, valid in resp cycle
resp  output  1  one-cycle completion pulse
error  output  1  sticky OR of err_flags
err_flags  output  3  sticky flags: [0] read&write together, [1] request/addr/wdata changed before resp, [2] addr[4:0]!=0
rd_count  output  CNT_W  completed reads, saturating
wr_count  output  CNT_W  completed writes, saturating

Behaviour:
- Reset (rst=0, async): state IDLE; resp=0; rdata=0; error=0; err_flags=0; rd_count=wr_count=0; all array lines cleared to 0. Reset mid-transaction aborts it: no resp, no array write.
- States: IDLE, BUSY, RESP.
- IDLE: if exactly one of read/write is high at a rising edge, capture cmd, line index, and wdata. Go to BUSY, or straight to RESP if LATENCY=1. If both are high, set err_flags[0], stay IDLE, ignore the request. If neither is high, stay IDLE.
- BUSY: internal counter. Resp is asserted during cycle t+LATENCY, where t is the cycle in which IDLE first saw the request.
- BUSY checks: each cycle compare read, write, addr, and wdata (wdata only for writes) against the captured values. Any mismatch, including the request dropping, sets err_flags[1]. The transaction still completes using the captured values.
- Entry to RESP, read: rdata is loaded from array[captured index]; resp=1 for exactly one cycle.
- Entry to RESP, write: array[captured index] is written with captured wdata on the edge entering RESP; resp=1; rdata unchanged.
- RESP -> IDLE unconditionally. resp is never high two cycles in a row, so the minimum request spacing is LATENCY+1 cycles.
- In the IDLE cycle after RESP, a new request (read/write high) is accepted; back-to-back transactions are legal.
- Unaligned addr: err_flags[2] is set at capture; the request is serviced at the line-aligned address (addr[4:0] ignored).
- Upper address bits above the index field are ignored, so addresses alias modulo LINES*32 bytes.
- rdata holds its last loaded value outside resp cycles; initiators must sample it only in the resp cycle.
- Counters: rd_count/wr_count increment on the edge entering RESP for the matching cmd and saturate at all-ones.
- err_flags bits are sticky until reset; error = |err_flags.
- Read-after-write to the same line returns the newly written data with no hazard window, because the write commits before IDLE.

Test Plan:
- Reset, then read addr 0x0000_0040 (LATENCY=4) -> resp high exactly at cycle t+4 for one cycle; rdata=0; rd_count=1; error=0.
- Write 0x0000_0060 wdata={8{32'hDEADBEEF}}, then back-to-back read of same addr in the IDLE cycle after resp -> read resp at +4 with rdata={8{32'hDEADBEEF}}; wr_count=1, rd_count=1.
- Write to 0x0000_0020 then read 0x0000_0220 (LINES=16, alias) -> rdata equals written line; error=0.
- read=1 and write=1 in the same cycle -> no resp within 10 cycles; err_flags=3'b001; error=1; array unchanged.
- Read of 0x0000_0080 with addr changed to 0x0000_00A0 two cycles after request -> resp at +4 with line 4 data; err_flags[1]=1. Read of 0x0000_0084 -> line 4 data; err_flags[2]=1.
- Assert rst=0 asynchronously mid-BUSY, release -> resp never pulses for the aborted request; all outputs and counters 0; subsequent read of any line returns 0.
